// File: rtl/ram_if_arbiter.sv
// rtl/ram_if_arbiter.sv - two-to-one Ram_if merge with round-robin or fixed-priority grant
module ram_if_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BE_W        = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              in_0_en_i,
    input  logic [ADDR_W-1:0] in_0_addr_i,
    input  logic [DATA_W-1:0] in_0_data_w_i,
    input  logic              in_0_we_i,
    input  logic [BE_W-1:0]   in_0_be_i,
    output logic [DATA_W-1:0] in_0_data_r_o,
    output logic              in_0_delay_o,

    input  logic              in_1_en_i,
    input  logic [ADDR_W-1:0] in_1_addr_i,
    input  logic [DATA_W-1:0] in_1_data_w_i,
    input  logic              in_1_we_i,
    input  logic [BE_W-1:0]   in_1_be_i,
    output logic [DATA_W-1:0] in_1_data_r_o,
    output logic              in_1_delay_o,

    output logic              out_en_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [DATA_W-1:0] out_data_w_o,
    output logic              out_we_o,
    output logic [BE_W-1:0]   out_be_o,
    input  logic [DATA_W-1:0] out_data_r_i,
    input  logic              out_delay_i
);

    logic busy_q, busy_d;
    logic owner_q, owner_d;
    logic last_q, last_d;

    logic blocked;
    logic grant_valid;
    logic winner;
    logic granted_0;
    logic granted_1;

    // A memory stall on the request in flight freezes arbitration entirely.
    assign blocked = busy_q & out_delay_i;

    always_comb begin
        grant_valid = 1'b0;
        winner      = 1'b0;
        if (!blocked) begin
            if (in_0_en_i && in_1_en_i) begin
                grant_valid = 1'b1;
                winner      = ROUND_ROBIN ? ~last_q : 1'b0;
            end else if (in_0_en_i) begin
                grant_valid = 1'b1;
            end else if (in_1_en_i) begin
                grant_valid = 1'b1;
                winner      = 1'b1;
            end
        end
    end

    assign granted_0 = grant_valid & ~winner;
    assign granted_1 = grant_valid & winner;

    assign out_en_o     = grant_valid;
    assign out_we_o     = grant_valid & (winner ? in_1_we_i : in_0_we_i);
    assign out_addr_o   = winner ? in_1_addr_i   : in_0_addr_i;
    assign out_data_w_o = winner ? in_1_data_w_i : in_0_data_w_i;
    assign out_be_o     = winner ? in_1_be_i     : in_0_be_i;

    assign in_0_data_r_o = out_data_r_i;
    assign in_1_data_r_o = out_data_r_i;

    assign in_0_delay_o = (busy_q & ~owner_q & out_delay_i) | (in_0_en_i & ~granted_0);
    assign in_1_delay_o = (busy_q &  owner_q & out_delay_i) | (in_1_en_i & ~granted_1);

    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (!blocked) begin
            busy_d = grant_valid;
            if (grant_valid) begin
                owner_d = winner;
                last_d  = winner;
            end
        end
    end

    // last_q resets to 1 so that in_0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: doc/ram_if_arbiter.md
# ram_if_arbiter

Two-to-one merge for the `Ram_if` protocol: two upstream requesters share a single downstream memory port. Requests are arbitrated per cycle, round-robin by default. The loser is stalled through its `delay` signal. The read response and memory stalls are routed back to the port that owns the request in flight. The block sits in the memory hierarchy wherever two masters share one RAM, for example instruction and data paths into one unified memory, and complements the address-based splitter in the same tree.

## Interface
- `ROUND_ROBIN`, default 1: 1 = round-robin priority; 0 = fixed priority, `in_0` always wins.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_0`  `Ram_if.client`  —  upstream port 0: `en`, `addr`, `data_w`, `we`, `be` in; `data_r`, `delay` out.
- `in_1`  `Ram_if.client`  —  upstream port 1, same signal set as `in_0`.
- `out`  `Ram_if.memory`  —  downstream port: `en`, `addr`, `data_w`, `we`, `be` out; `data_r`, `delay` in.

## Operation
- **Protocol rule.** While an upstream port sees `delay`=1, its client holds `en`, `addr`, `data_w`, `we` and `be` stable. A stalled request is retried, never dropped.
- **Registered state.**
  - `busy_d`: a request was issued last cycle, so this cycle is its response cycle.
  - `owner_d`: the port that issued that request.
  - `last_d`: the most recently granted port (round-robin pointer).
- **Blocked.** `blocked = busy_d & out.delay`. The downstream memory is stalling the request in flight, so no new grant is issued.
- **Grant.** Evaluated combinationally each cycle when not blocked:
  - Only one port has `en`=1: that port wins.
  - Both ports have `en`=1, `ROUND_ROBIN`=1: the port that is not `last_d` wins.
  - Both ports have `en`=1, `ROUND_ROBIN`=0: `in_0` wins.
  - Neither port has `en`=1: no grant.
- **Downstream drive.**
  - `out.addr`, `out.data_w` and `out.be` come from the winner, or from `in_0` when there is no grant.
  - `out.en` and `out.we` come from the winner; both are 0 when there is no grant or `blocked`=1.
- **Response.** `in_0.data_r` and `in_1.data_r` both equal `out.data_r` at all times. Only `delay` distinguishes the two ports.
- **Upstream delay.** `in_i.delay = (busy_d & owner_d==i & out.delay) | (in_i.en & ~granted_i)`.
  - A port that loses arbitration, or is locked out by `blocked`, sees `delay`=1.
- **State update.**
  - When `blocked`=1: `busy_d`, `owner_d` and `last_d` hold their values.
  - Otherwise: `busy_d <= grant_valid`. If there is a grant, `owner_d` and `last_d` take the winner's index.
- **Reset.** Sets `busy_d`=0, `owner_d`=0 and `last_d`=1, so `in_0` wins the first contention.
  - After reset, with no upstream `en`: `out.en`=0, `out.we`=0, and both `in_*.delay`=0.
  - A reset during a response cycle or a stall discards the in-flight ownership. The `out.delay` seen the next cycle is not forwarded to either port.

## Timing
- Grant is combinational: upstream `en` in cycle t produces `out.en` in cycle t, with zero added request latency.
- Response: `out.data_r`/`out.delay` at t+1 belong to `owner_d`; there is no added response latency.
- Back-to-back operation is fully pipelined:
  - A new grant may issue in the response cycle of the previous request, unless `blocked`=1.
  - Sustained throughput is one request per cycle.
- Contention: the loser is issued no earlier than the cycle after the winner's grant. With `ROUND_ROBIN`=1, a continuously requesting port waits at most one grant.
- Stall: while `out.delay`=1 in a response cycle:
  - The owner sees `delay`=1.
  - Any requesting port sees `delay`=1.
  - `out.en`=0.
  - The first cycle with `out.delay`=0 releases arbitration in that same cycle.
- Simultaneous events:
  - An owner that has a response pending and also asserts a new `en` in the same cycle is arbitrated normally.
  - In that cycle its `delay` reflects `out.delay` OR lost arbitration.

## Test plan
- Reset, then `in_1` reads `addr`=0x40 alone → `out.en`=1, `out.addr`=0x40 in the same cycle; at t+1 `in_1.data_r`=memory word and `in_1.delay`=0; `in_0.delay`=0 throughout.
- Both ports assert `en` at t (`in_0` `addr`=0x10, `in_1` `addr`=0x20) → t: 0x10 issued and `in_1.delay`=1; t+1: 0x20 issued, `in_0` receives the 0x10 data, `in_1.delay`=0.
- Both ports request continuously for 8 cycles, `ROUND_ROBIN`=1 → grants alternate 0,1,0,1,…; each port gets 4 grants. With `ROUND_ROBIN`=0 → `in_0` gets all 8 grants and `in_1.delay` stays 1.
- `in_0` write at t; memory holds `out.delay`=1 for t+1..t+3; `in_1` requests at t+1 → `out.en`=0 and both `delay`=1 for t+1..t+3; at t+4 `in_0.delay`=0 and `in_1` is granted.
- Pulse `reset` during the t+2 stall of the previous scenario → at t+3 `busy_d`=0, `out.delay` is not forwarded, `out.en` is driven by fresh arbitration, and `in_0` wins the next contention.
- Byte write from `in_1` with `be`=4'b0010, `data_w`=0xAABBCCDD → `out.we`=1, `out.be`=4'b0010 and `out.data_w`=0xAABBCCDD in the same cycle; `in_0` is unaffected.
